// File: rtl/mul_share_pkg.sv
// Shared types and sizing helpers for the multiplier-sharing scheduler.
package mul_share_pkg;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    // Widest requester index supported (NREQ up to 16).
    localparam int IDW_MAX = 4;

    function automatic int IDW(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic               valid;
        logic [IDW_MAX-1:0] id;
    } stage_ctl_t;

endpackage

// File: rtl/MulUns.sv
// Unsigned multiplier: partial products reduced by a carry-save chain, then a final carry-propagate adder.
// Purely combinational; speed 0 selects a ripple adder, anything else a log-depth prefix adder.
module MulUns #(
    parameter int widthX = 16,
    parameter int widthY = 16,
    parameter int speed  = 2
) (
    input  logic [widthX-1:0]        X,
    input  logic [widthY-1:0]        Y,
    output logic [widthX+widthY-1:0] P
);

    localparam int PW = widthX + widthY;

    logic [PW-1:0] w_s;
    logic [PW-1:0] w_c;

    // Carries shifted out of the top bit are dropped: the true product always fits in PW bits.
    always_comb begin
        logic [PW-1:0] s, c, pp, t;
        s  = '0;
        c  = '0;
        pp = '0;
        t  = '0;
        for (int i = 0; i < widthX; i++) begin
            pp = X[i] ? (PW'(Y) << i) : '0;
            t  = s ^ c ^ pp;
            c  = ((s & c) | (s & pp) | (c & pp)) << 1;
            s  = t;
        end
        w_s = s;
        w_c = c;
    end

    if (speed == 0) begin : g_ripple
        always_comb begin
            logic cy;
            cy = 1'b0;
            P  = '0;
            for (int i = 0; i < PW; i++) begin
                P[i] = w_s[i] ^ w_c[i] ^ cy;
                cy   = (w_s[i] & w_c[i]) | (cy & (w_s[i] ^ w_c[i]));
            end
        end
    end else begin : g_prefix
        // Descending index within a level so each step reads the previous level's value.
        always_comb begin
            logic [PW-1:0] g, p;
            g = w_s & w_c;
            p = w_s ^ w_c;
            for (int d = 1; d < PW; d = d * 2) begin
                for (int i = PW - 1; i >= d; i--) begin
                    g[i] = g[i] | (p[i] & g[i-d]);
                    p[i] = p[i] & p[i-d];
                end
            end
            P = (w_s ^ w_c) ^ {g[PW-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last accepted one.
// Grant is combinational from Req and the pointer; the pointer moves only when Advance is high.
module mul_rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = IDW(NREQ)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] Req,
    input  logic            Advance,
    output logic [NREQ-1:0] Grant,
    output logic [IW-1:0]   GrantId
);

    logic [IW-1:0] r_ptr;
    logic          w_found;

    // Scan from farthest to nearest so the nearest requester after r_ptr wins.
    always_comb begin
        logic [IW-1:0] idx;
        Grant   = '0;
        GrantId = '0;
        w_found = 1'b0;
        idx     = '0;
        for (int off = NREQ; off >= 1; off--) begin
            idx = IW'((int'(r_ptr) + off) % NREQ);
            if (Req[idx]) begin
                GrantId = idx;
                w_found = 1'b1;
            end
        end
        if (w_found) begin
            Grant[GrantId] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ptr <= IW'(NREQ - 1);
        end else if (Advance) begin
            r_ptr <= GrantId;
        end
    end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one MulUns among NREQ requesters with round-robin grants; LAT cycles accept-to-response.
// Elastic stages collapse bubbles; RspReady low stalls the pipe and, once full, drops all ReqReady.
module mul_share_sched
    import mul_share_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int widthX = 16,
    parameter int widthY = 16,
    parameter int speed  = 2,
    parameter int LAT    = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NREQ-1:0]            ReqValid,
    output logic [NREQ-1:0]            ReqReady,
    input  logic [NREQ*widthX-1:0]     ReqX,
    input  logic [NREQ*widthY-1:0]     ReqY,
    output logic                       RspValid,
    input  logic                       RspReady,
    output logic [IDW(NREQ)-1:0]       RspId,
    output logic [widthX+widthY-1:0]   RspP,
    output logic                       Busy
);

    localparam int IW   = IDW(NREQ);
    localparam int PW   = widthX + widthY;
    localparam int NSTG = (LAT < LAT_MIN) ? LAT_MIN : ((LAT > LAT_MAX) ? LAT_MAX : LAT);

    logic [NREQ-1:0]   w_grant;
    logic [IW-1:0]     w_gid;
    logic              w_accept;
    logic [widthX-1:0] w_selx;
    logic [widthY-1:0] w_sely;
    logic [widthX-1:0] r_x;
    logic [widthY-1:0] r_y;
    logic [PW-1:0]     w_prod;
    logic [NSTG-1:0]   w_vld;
    logic [NSTG-1:0]   w_load;
    stage_ctl_t        r_ctl [NSTG];
    logic [PW-1:0]     w_sp  [NSTG];

    mul_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .Req     (ReqValid),
        .Advance (w_accept),
        .Grant   (w_grant),
        .GrantId (w_gid)
    );

    MulUns #(.widthX(widthX), .widthY(widthY), .speed(speed)) u_mul (
        .X (r_x),
        .Y (r_y),
        .P (w_prod)
    );

    // Held off during reset so nothing can be accepted into a pipe that is being cleared.
    assign ReqReady = w_grant & {NREQ{w_load[0] & ~RST}};
    assign w_accept = |ReqReady;

    always_comb begin
        w_selx = '0;
        w_sely = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_selx = ReqX[i*widthX +: widthX];
                w_sely = ReqY[i*widthY +: widthY];
            end
        end
    end

    // A stage may load when it is empty or its occupant moves on this cycle.
    always_comb begin
        logic ld;
        ld = RspReady;
        for (int k = NSTG - 1; k >= 0; k--) begin
            w_vld[k]  = r_ctl[k].valid;
            ld        = ~r_ctl[k].valid | ld;
            w_load[k] = ld;
        end
    end

    assign w_sp[0] = w_prod;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        if (k == 0) begin : g_s0
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_ctl[0] <= '0;
                    r_x      <= '0;
                    r_y      <= '0;
                end else if (w_load[0]) begin
                    r_ctl[0].valid <= w_accept;
                    r_ctl[0].id    <= IDW_MAX'(w_gid);
                    r_x            <= w_selx;
                    r_y            <= w_sely;
                end
            end
        end else begin : g_sn
            logic [PW-1:0] r_p;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_ctl[k] <= '0;
                    r_p      <= '0;
                end else if (w_load[k]) begin
                    r_ctl[k] <= r_ctl[k-1];
                    r_p      <= w_sp[k-1];
                end
            end
            assign w_sp[k] = r_p;
        end
    end

    assign RspValid = r_ctl[NSTG-1].valid;
    assign RspId    = IW'(r_ctl[NSTG-1].id);
    assign RspP     = w_sp[NSTG-1];
    assign Busy     = |w_vld;

endmodule
